fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  PC, instruction register (IR) and memory-data register (MDR) stage of the TinyMIPS multicycle core.
//  Sits between memory and the controller.
//  - Drives the memory address.
//  - Assembles the 32-bit instruction byte-by-byte under controller irwrite.
//  - Presents op[5:0] and the decoded fields to the controller and the register file.
//  - Checks the controller's fetch-byte sequence and reports protocol errors.
// PARAMETERS
//  WIDTH     8   datapath/address width (PC, MDR, ALU buses)
//  PC_RESET  0   PC value loaded on reset
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous reset, active-low
//  memdata     in   WIDTH  byte read from memory
//  irwrite     in   4      one-hot IR byte write enable from controller
//  pcen        in   1      PC write enable
//  pcsource    in   2      next-PC select: 00 aluresult, 01 aluout, 10 jump target, 11 hold
//  iord        in   1      address select: 0 PC, 1 aluout
//  aluresult   in   WIDTH  combinational ALU output
//  aluout      in   WIDTH  registered ALU output
//  memaddr     out  WIDTH  memory address
//  pc          out  WIDTH  current PC
//  instr       out  32     assembled instruction
//  op          out  6      instr[31:26], to controller
//  rs,rt,rd    out  5 each instr[25:21], [20:16], [15:11]
//  funct       out  6      instr[5:0]
//  imm         out  16     instr[15:0]
//  mdr         out  WIDTH  memdata registered every cycle
//  ir_valid    out  1      full in-order 4-byte fetch completed
//  fetch_err   out  1      sticky fetch-protocol error
// BEHAVIOUR
//  Reset (rst=0, async), all cleared/registered:
//   - pc=PC_RESET; instr=0; mdr=0; ir_valid=0; fetch_err=0; expected byte index=0.
//  memaddr: combinational = iord ? aluout : pc. Zero latency.
//  PC update: on clk when pcen=1 and pcsource!=11.
//   - 00 -> aluresult; 01 -> aluout.
//   - 10 -> {instr[WIDTH-3:0],2'b00}, truncated to WIDTH.
//   - pcsource=11 or pcen=0: PC holds.
//  IR write: irwrite[k]=1 loads instr[8k+7:8k] <= memdata[7:0] on the edge (byte 0 is LSB).
//   - The IR byte load and the PC update in the same cycle both take effect.
//   - memaddr and the loaded byte use pre-edge values.
//  Decoded fields are wires off instr. They are stable while irwrite=0.
//  Sequence tracker: 2-bit expected index exp, reset 0.
//   - One-hot irwrite[k], k==exp: exp <= k+1 (wraps 3->0).
//     On k==3, ir_valid <= 1 only if bytes 0..2 of this instruction were loaded in order.
//   - One-hot irwrite[k], k!=exp: byte still written; fetch_err <= 1; exp <= k+1; ir_valid <= 0.
//   - irwrite[0] always clears ir_valid (start of a new fetch), in order or not.
//   - Multi-hot irwrite: every selected byte written; fetch_err <= 1; exp <= 0; ir_valid <= 0.
//   - irwrite=0: tracker and ir_valid hold.
//  fetch_err clears only on reset.
//  Reset mid-fetch: partial instruction discarded (instr=0, exp=0). The next fetch must begin at byte 0.
//  mdr loads memdata every cycle, unconditionally.
// STRUCTURE
//  tinymips_pkg (shared):
//   - pcsource encodings PCSRC_ALU/ALUOUT/JUMP/HOLD
//   - opcode constants LB, SB, RTYPE, BEQ, J, ADDI
//   - IR field bit positions
//  One sub-module: pc_reg (WIDTH-bit enabled register with async active-low reset and reset value PC_RESET).
//  Remaining logic inline: IR byte lanes, tracker, muxes.
// TESTING
//  1. Reset: rst=0 mid-run -> pc=0, instr=0, ir_valid=0, fetch_err=0 immediately, no clock edge needed.
//  2. In-order fetch of 0x20A30005 (memdata 05,00,A3,20 with irwrite 0001,0010,0100,1000; pcen=1, pcsource=00, aluresult=pc+1):
//     -> instr=0x20A30005, op=001000, rs=5, rt=3, imm=0x0005, pc=4, ir_valid=1 after the 4th edge, fetch_err=0.
//  3. Jump: instr=0x0800000C, pcen=1, pcsource=10 -> pc=0x30. pcsource=11 with pcen=1 -> pc unchanged.
//  4. iord=1, aluout=0x44 -> memaddr=0x44 same cycle. iord=0 -> memaddr=pc.
//     Next edge: mdr = memdata presented.
//  5. Out-of-order irwrite 0001 then 0100 -> byte 2 written, fetch_err=1 and stays 1.
//     A following clean 0..3 fetch -> ir_valid=1 and fetch_err still 1.
//  6. irwrite=0011, memdata=0xAB -> instr[15:0]=0xABAB, fetch_err=1, ir_valid=0.
//     Then reset asserted between bytes 1 and 2 -> all cleared.

Source files
------------

// File: rtl/tinymips_pkg.sv
// Shared TinyMIPS definitions: next-PC select encodings, opcode constants and
// instruction field positions used by the fetch stage and the controller.
package tinymips_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_e;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_LSB   = 0;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: enabled load with an asynchronous active-low
// reset to a configurable start address.
module pc_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// TinyMIPS multicycle fetch stage: PC, byte-assembled instruction register,
// memory data register and a checker for the controller's byte-write order.
module fetch_unit
    import tinymips_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] memdata,
    input  logic [3:0]       irwrite,
    input  logic             pcen,
    input  logic [1:0]       pcsource,
    input  logic             iord,
    input  logic [WIDTH-1:0] aluresult,
    input  logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] memaddr,
    output logic [WIDTH-1:0] pc,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [5:0]       funct,
    output logic [15:0]      imm,
    output logic [WIDTH-1:0] mdr,
    output logic             ir_valid,
    output logic             fetch_err
);

    logic [WIDTH-1:0] pc_next;
    logic             pc_load;
    logic [1:0]       exp_idx;
    logic [1:0]       exp_next;
    logic             clean;
    logic             clean_next;
    logic             valid_next;
    logic             err_next;
    logic             is_onehot;
    logic [1:0]       byte_idx;

    assign memaddr = iord ? aluout : pc;
    assign pc_load = pcen && (pcsource != PCSRC_HOLD);

    always_comb begin
        pc_next = pc;
        case (pcsource)
            PCSRC_ALU:    pc_next = aluresult;
            PCSRC_ALUOUT: pc_next = aluout;
            PCSRC_JUMP:   pc_next = {instr[WIDTH-3:0], 2'b00};
            default:      pc_next = pc;
        endcase
    end

    pc_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (pc_load),
        .d   (pc_next),
        .q   (pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdr   <= '0;
            instr <= '0;
        end else begin
            mdr <= memdata;
            for (int k = 0; k < 4; k++) begin
                if (irwrite[k]) begin
                    instr[8*k +: 8] <= memdata[7:0];
                end
            end
        end
    end

    assign is_onehot = (irwrite != 4'b0000) && ((irwrite & (irwrite - 4'd1)) == 4'b0000);

    always_comb begin
        byte_idx = 2'd0;
        case (irwrite)
            4'b0010: byte_idx = 2'd1;
            4'b0100: byte_idx = 2'd2;
            4'b1000: byte_idx = 2'd3;
            default: byte_idx = 2'd0;
        endcase
    end

    // 'clean' remembers whether every byte of the current instruction so far
    // arrived in order; a byte-0 write always begins a fresh instruction.
    always_comb begin
        exp_next   = exp_idx;
        clean_next = clean;
        valid_next = ir_valid;
        err_next   = fetch_err;
        if (irwrite != 4'b0000) begin
            if (!is_onehot) begin
                exp_next   = 2'd0;
                clean_next = 1'b0;
                valid_next = 1'b0;
                err_next   = 1'b1;
            end else begin
                exp_next = byte_idx + 2'd1;
                if (byte_idx != exp_idx) begin
                    err_next = 1'b1;
                end
                if (byte_idx == 2'd0) begin
                    clean_next = 1'b1;
                    valid_next = 1'b0;
                end else if (byte_idx != exp_idx) begin
                    clean_next = 1'b0;
                    valid_next = 1'b0;
                end else if (byte_idx == 2'd3) begin
                    valid_next = clean;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_idx   <= 2'd0;
            clean     <= 1'b0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            exp_idx   <= exp_next;
            clean     <= clean_next;
            ir_valid  <= valid_next;
            fetch_err <= err_next;
        end
    end

    assign op    = instr[OP_LSB +: 6];
    assign rs    = instr[RS_LSB +: 5];
    assign rt    = instr[RT_LSB +: 5];
    assign rd    = instr[RD_LSB +: 5];
    assign funct = instr[FUNCT_LSB +: 6];
    assign imm   = instr[IMM_LSB +: 16];

endmodule
